// File: rtl/pipe_game_pkg.sv
// Shared pipe-game constants: GameState encoding, screen/pipe geometry, BCD helper.
package pipe_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DEAD = 2'b10
  } gameState_t;

  localparam int SCREEN_W = 640;
  localparam int FLOOR_Y  = 428;
  localparam int PIPE_W   = 90;
  localparam int CAP_H    = 33;
  localparam int GAP      = 150;

  // Stage-1 snapshot, zero-extended so no geometry sum can wrap.
  typedef struct packed {
    logic [16:0] pos;
    logic [16:0] gapTop;
    logic [16:0] birdY;
    logic        button;
  } sample_t;

  function automatic logic [11:0] bcdInc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] != 4'd9) r[3:0] = v[3:0] + 4'd1;
      else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) r[7:4] = v[7:4] + 4'd1;
        else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_collision_scorer_bcd.sv
// bcd_counter3: 3-digit BCD counter with sync clear, increment enable, saturation at 999.
module bcd_counter3
  import pipe_game_pkg::*;
(
  input  logic        Clks,
  input  logic        Reset,
  input  logic        Clear,
  input  logic        Inc,
  output logic [11:0] Count,
  output logic [11:0] CountNext
);

  // CountNext is exported so the caller can compare against the post-increment value.
  always_comb begin
    CountNext = Count;
    if (Clear)    CountNext = 12'h000;
    else if (Inc) CountNext = bcdInc(Count);
  end

  always_ff @(posedge Clks) begin
    if (!Reset) Count <= 12'h000;
    else        Count <= CountNext;
  end

endmodule

// File: rtl/pipe_collision_scorer.sv
// Bird/pipe/floor collision, BCD pass scoring and IDLE/PLAY/DEAD game FSM.
// Floor kill is enabled by defining PIPE_SCORER_FLOOR_KILL_EN.
module pipe_collision_scorer
  import pipe_game_pkg::*;
#(
  parameter int BIRD_X  = 200,
  parameter int BIRD_W  = 34,
  parameter int BIRD_H  = 24,
  parameter int HOLDOFF = 64
) (
  input  logic        Clks,
  input  logic        Reset,
  input  logic        FrameTick,
  input  logic        Button,
  input  logic [15:0] PipesPosition,
  input  logic [15:0] PipesLong,
  input  logic [15:0] BirdY,
  output logic        Status,
  output logic        Collision,
  output logic [11:0] Score,
  output logic [11:0] HighScore,
  output logic [1:0]  GameState
);

  localparam int STAGES = 2;
  localparam int HW     = $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLDOFF);
  localparam logic [16:0] BIRD_L = 17'(BIRD_X);
  localparam logic [16:0] BIRD_R = 17'(BIRD_X + BIRD_W);
  localparam logic [16:0] BH     = 17'(BIRD_H);
  localparam logic [16:0] PW     = 17'(PIPE_W);
  localparam logic [16:0] CH     = 17'(CAP_H);
  localparam logic [16:0] GP     = 17'(GAP);
`ifdef PIPE_SCORER_FLOOR_KILL_EN
  localparam logic [16:0] FY     = 17'(FLOOR_Y);
`endif

  logic [STAGES:1] vldPipe;
  sample_t         s1;
  logic            hx, hitComb;
  logic            hitQ, passQ, rearmQ, btnQ;
  gameState_t      state;
  logic            armed;
  logic [HW-1:0]   holdCnt;
  logic            tickQ, incEn, clrEn;
  logic [11:0]     scoreNext;

  always_ff @(posedge Clks) begin
    if (!Reset) vldPipe <= '0;
    else        vldPipe <= {vldPipe[STAGES-1:1], FrameTick};
  end

  always_ff @(posedge Clks) begin
    if (FrameTick) begin
      s1.pos    <= {1'b0, PipesPosition};
      s1.gapTop <= {1'b0, PipesLong};
      s1.birdY  <= {1'b0, BirdY};
      s1.button <= Button;
    end
  end

  always_comb begin
    hx      = (BIRD_R >= s1.pos) && (BIRD_L <= s1.pos + PW);
    hitComb = hx && ((s1.birdY <= s1.gapTop + CH) || (s1.birdY + BH >= s1.gapTop + GP));
`ifdef PIPE_SCORER_FLOOR_KILL_EN
    hitComb = hitComb || (s1.birdY + BH >= FY);
`endif
  end

  always_ff @(posedge Clks) begin
    if (vldPipe[1]) begin
      hitQ   <= hitComb;
      passQ  <= armed && (s1.pos + PW < BIRD_L);
      rearmQ <= s1.pos > BIRD_R;
      btnQ   <= s1.button;
    end
  end

  assign tickQ = vldPipe[STAGES];
  assign incEn = tickQ && (state == ST_PLAY) && passQ;
  assign clrEn = tickQ && (state == ST_IDLE) && !btnQ;

  bcd_counter3 uScore (
    .Clks      (Clks),
    .Reset     (Reset),
    .Clear     (clrEn),
    .Inc       (incEn),
    .Count     (Score),
    .CountNext (scoreNext)
  );

  always_ff @(posedge Clks) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      Status    <= 1'b0;
      Collision <= 1'b0;
      HighScore <= 12'h000;
      armed     <= 1'b1;
      holdCnt   <= '0;
    end else begin
      Collision <= 1'b0;
      if (tickQ) begin
        if (rearmQ) armed <= 1'b1;
        case (state)
          ST_IDLE: if (!btnQ) begin
            state  <= ST_PLAY;
            Status <= 1'b1;
            armed  <= 1'b1;
          end
          ST_PLAY: begin
            if (passQ) armed <= 1'b0;
            // scoreNext already includes a same-tick pass
            if (hitQ) begin
              state     <= ST_DEAD;
              Status    <= 1'b0;
              Collision <= 1'b1;
              holdCnt   <= '0;
              if (scoreNext > HighScore) HighScore <= scoreNext;
            end
          end
          ST_DEAD: begin
            if (holdCnt < HOLD_MAX) holdCnt <= holdCnt + 1'b1;
            else if (btnQ) begin
              state   <= ST_IDLE;
              holdCnt <= '0;
            end
          end
          default: begin
            state  <= ST_IDLE;
            Status <= 1'b0;
          end
        endcase
      end
    end
  end

  assign GameState = state;

endmodule

// File: tb/tb_pipe_collision_scorer.sv
// Directed bench for pipe_collision_scorer: reset, latency, scoring, death, holdoff, saturation.
module tb_pipe_collision_scorer;

  logic        Clks = 1'b0;
  logic        Reset = 1'b0;
  logic        FrameTick = 1'b0;
  logic        Button = 1'b1;
  logic [15:0] PipesPosition = 16'd640;
  logic [15:0] PipesLong = 16'd100;
  logic [15:0] BirdY = 16'd180;
  logic        Status, Collision;
  logic [11:0] Score, HighScore;
  logic [1:0]  GameState;

  int errors = 0;
  int checks = 0;

  always #5 Clks = ~Clks;

  pipe_collision_scorer dut (
    .Clks          (Clks),
    .Reset         (Reset),
    .FrameTick     (FrameTick),
    .Button        (Button),
    .PipesPosition (PipesPosition),
    .PipesLong     (PipesLong),
    .BirdY         (BirdY),
    .Status        (Status),
    .Collision     (Collision),
    .Score         (Score),
    .HighScore     (HighScore),
    .GameState     (GameState)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One game tick; returns 2 cycles after the sampling edge, when results are visible.
  task automatic tick(input int pos, input int lng, input int y, input logic btn);
    PipesPosition = 16'(pos);
    PipesLong     = 16'(lng);
    BirdY         = 16'(y);
    Button        = btn;
    FrameTick     = 1'b1;
    @(negedge Clks);
    FrameTick = 1'b0;
    @(negedge Clks);
    @(negedge Clks);
  endtask

  task automatic onePass();
    tick(0, 100, 180, 1'b1);
    tick(640, 100, 180, 1'b1);
  endtask

  task automatic die();
    tick(150, 100, 120, 1'b1);
  endtask

  task automatic restart(input string tag);
    repeat (64) tick(640, 100, 180, 1'b0);
    chk({tag, "_holdoff_dead"}, 16'(GameState), 16'h2);
    tick(640, 100, 180, 1'b1);
    chk({tag, "_release_idle"}, 16'(GameState), 16'h0);
    tick(640, 100, 180, 1'b0);
    chk({tag, "_play"}, 16'(GameState), 16'h1);
    chk({tag, "_score_clr"}, 16'(Score), 16'h000);
  endtask

  initial begin
    // Reset with Button low and FrameTick held active
    Reset = 1'b0; Button = 1'b0; FrameTick = 1'b1;
    repeat (4) @(negedge Clks);
    chk("rst_state", 16'(GameState), 16'h0);
    chk("rst_status", 16'(Status), 16'h0);
    chk("rst_coll", 16'(Collision), 16'h0);
    chk("rst_score", 16'(Score), 16'h000);
    chk("rst_hs", 16'(HighScore), 16'h000);
    FrameTick = 1'b0; Reset = 1'b1;
    repeat (3) @(negedge Clks);
    chk("post_rst_idle", 16'(GameState), 16'h0);
    chk("post_rst_coll", 16'(Collision), 16'h0);

    // Start: state changes exactly 2 cycles after the tick
    PipesPosition = 16'd640; PipesLong = 16'd100; BirdY = 16'd180; Button = 1'b0;
    FrameTick = 1'b1;
    @(negedge Clks);
    FrameTick = 1'b0;
    @(negedge Clks);
    chk("lat1_idle", 16'(GameState), 16'h0);
    chk("lat1_status", 16'(Status), 16'h0);
    @(negedge Clks);
    chk("start_play", 16'(GameState), 16'h1);
    chk("start_status", 16'(Status), 16'h1);
    chk("start_score", 16'(Score), 16'h000);

    // Two full sweeps through the gap, one point each
    for (int p = 300; p >= 0; p -= 30) tick(p, 100, 180, 1'b1);
    tick(640, 100, 180, 1'b1);
    chk("sweep1_score", 16'(Score), 16'h001);
    chk("sweep1_alive", 16'(Status), 16'h1);
    for (int p = 300; p >= 0; p -= 30) tick(p, 100, 180, 1'b1);
    tick(640, 100, 180, 1'b1);
    chk("sweep2_score", 16'(Score), 16'h002);
    chk("sweep_nocoll", 16'(Collision), 16'h0);

    // Top-cap hit
    die();
    chk("hit_coll", 16'(Collision), 16'h1);
    chk("hit_status", 16'(Status), 16'h0);
    chk("hit_state", 16'(GameState), 16'h2);
    @(negedge Clks);
    chk("hit_coll_pulse", 16'(Collision), 16'h0);
    chk("hit_hs", 16'(HighScore), 16'h002);

    // Game 2: 5 points
    restart("g2");
    repeat (5) onePass();
    chk("g2_score", 16'(Score), 16'h005);
    die();
    chk("g2_hs", 16'(HighScore), 16'h005);

    // Game 3: 7 points beats 5
    restart("g3");
    repeat (7) onePass();
    die();
    chk("g3_hs", 16'(HighScore), 16'h007);

    // Game 4: lower score leaves HighScore alone
    restart("g4");
    repeat (3) onePass();
    die();
    chk("g4_score", 16'(Score), 16'h003);
    chk("g4_hs_kept", 16'(HighScore), 16'h007);

    // Game 5: BCD carry into hundreds, then saturation
    restart("g5");
    repeat (99) onePass();
    chk("bcd_099", 16'(Score), 16'h099);
    onePass();
    chk("bcd_100", 16'(Score), 16'h100);
    repeat (899) onePass();
    chk("bcd_999", 16'(Score), 16'h999);
    onePass();
    chk("bcd_sat", 16'(Score), 16'h999);

    // Floor contact, no pipe overlap
    tick(640, 100, 410, 1'b1);
`ifdef PIPE_SCORER_FLOOR_KILL_EN
    chk("floor_state", 16'(GameState), 16'h2);
    chk("floor_coll", 16'(Collision), 16'h1);
    chk("floor_hs", 16'(HighScore), 16'h999);
`else
    chk("floor_state", 16'(GameState), 16'h1);
    chk("floor_coll", 16'(Collision), 16'h0);
    chk("floor_hs", 16'(HighScore), 16'h007);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
